serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial W-bit adder/subtractor: one shared full-adder cell, one bit per clock, LSB first.
- Start/busy/done handshake.
- Area-reduced, multi-cycle counterpart to the combinational 4-bit parallel adder.
- Adds subtract mode (two's-complement: invert B, carry-in 1) with a borrow flag.
- Sits beside the parallel adder in the lab arithmetic set. Benches compare its results against the parallel adder.

Parameters:
- W, 4, operand/result width in bits (legal 2..16)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = add, 1 = subtract (A - B); latched with start
- a  input  W  operand A; latched with start
- b  input  W  operand B; latched with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result/cout are updated
- result  output  W  sum or difference, held between operations
- cout  output  1  add: carry-out; sub: borrow (1 when A < B unsigned)

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, result=0, cout=0; internal shift registers, carry and bit counter cleared. Applies immediately, including mid-operation. The in-flight operation is discarded and produces no done.
- State IDLE:
  - start=1 latches a, b, sub into internal registers.
  - Carry register is set to sub. In subtract mode b is latched inverted.
  - Counter is set to 0; next state SHIFT.
- State SHIFT (busy=1), each cycle:
  - s = a_sh[0] ^ b_sh[0] ^ c; c_next = majority(a_sh[0], b_sh[0], c).
  - a_sh and b_sh shift right by one.
  - s is inserted at the MSB of the internal sum register, which shifts right.
  - Counter increments. When counter reaches W-1, next state is DONE.
- State DONE (busy=0, done=1 for exactly this cycle):
  - result is loaded from the internal sum register on entry.
  - cout = final carry (add) or ~final carry (sub).
  - Next state IDLE. If start=1 in this cycle, the new operation is accepted exactly as from IDLE and next state is SHIFT.
- Latency: start sampled at edge k; busy high for cycles k+1..k+W; done high in cycle k+W+1.
- start while in SHIFT is ignored; no queuing.
- Operands/sub may change freely after the start edge; only latched copies are used.
- result/cout do not change during SHIFT; they hold the previous operation's values.
- Width: all arithmetic is modulo 2^W. Carry/borrow is exported only via cout.
- Special case a == b in subtract mode: result 0, cout 0.

Optional Feature:
- Macro SERIAL_ADDSUB_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB. Carry into the MSB is captured on the last SHIFT cycle.
  - ovf is updated together with result in DONE, held otherwise, and reset to 0.
- Not defined: no ovf port and no associated logic. All other behaviour is identical.

Decomposition:
- Package addsub_pkg:
  - state enum (IDLE, SHIFT, DONE) as a 2-bit typedef
  - default width constant ADDSUB_W = 4
  - counter width derived as $clog2(W)
- One natural sub-module: fa_cell (combinational full adder: a, b, cin -> s, cout), instantiated once in the datapath.

Test Plan:
- Reset, then add 0010 + 0001 -> busy for 4 cycles, done pulse in cycle 5 after start, result=0011, cout=0.
- Add 1111 + 1111 -> result=1110, cout=1. Add 1000 + 0111 -> result=1111, cout=0. Cross-check the full 8-vector sweep against the parallel adder.
- Subtract 0100 - 0011 -> result=0001, cout=0. Subtract 0011 - 0100 -> result=1111, cout=1. Subtract 0101 - 0101 -> result=0000, cout=0.
- Assert start with a different operand pair 2 cycles into SHIFT -> ignored. First result unchanged, exactly one done pulse.
- Drop rst_n low mid-SHIFT -> all outputs 0 immediately, no done. Restart 0110 + 0101 -> result=1011.
- With SERIAL_ADDSUB_OVF_EN: add 0111 + 0001 -> result=1000, ovf=1, cout=0. Subtract 1000 - 0001 -> result=0111, ovf=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package addsub_pkg;

    localparam int ADDSUB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A 1-bit counter still needs one bit even when $clog2 would return 0.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder; the only arithmetic cell in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial W-bit adder/subtractor, LSB first, one bit per clock.
// Optional signed-overflow output ovf when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int W = ADDSUB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state, state_nx;
    logic [W-1:0]   a_sh, b_sh, sum_sh;
    logic           carry, sub_q;
    logic [CW-1:0]  cnt;
    logic           load, last_bit;
    logic           fa_s, fa_c;

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;
        last_bit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    last_bit = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at load and the carry seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            sub_q <= sub;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_s, sum_sh[W-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                result <= {fa_s, sum_sh[W-1:1]};
                cout   <= fa_c ^ sub_q;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // On the last bit the carry register holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ovf <= 1'b0;
        else if (last_bit) ovf <= carry ^ fa_c;
    end
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with a reference-model scoreboard.
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           passed = 0;
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;

    serial_addsub #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Parallel-adder reference.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t       e;
        logic [W:0] t;
        if (!s) begin
            t     = {1'b0, x} + {1'b0, y};
            e.res = t[W-1:0];
            e.co  = t[W];
            e.ov  = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
        end else begin
            e.res = x - y;
            e.co  = (x < y);
            e.ov  = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input string tag, input int inject);
        exp_t e;
        int   nbusy;
        int   ndone;
        bit   seen;
        bit   held;
        a = x; b = y; sub = s; start = 1'b1;
        sb.push_back(model(x, y, s));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom_range(0, (1 << W) - 1));
        b = W'($urandom_range(0, (1 << W) - 1));
        sub = 1'($urandom_range(0, 1));
        nbusy = 0; seen = 0; held = 1;
        for (int i = 0; i < W + 8; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nbusy++;
            if (result !== last_res) held = 0;
            start = (i == inject);
            if (i == inject) begin
                a = ~x;
                b = x;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, nbusy, W);
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_held"}, held, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                check({tag, "_result"}, result, e.res);
                check({tag, "_cout"}, cout, e.co);
`ifdef SERIAL_ADDSUB_OVF_EN
                check({tag, "_ovf"}, ovf, e.ov);
`endif
            end
            last_res = e.res;
        end else begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end
        if (inject >= 0) begin
            ndone = 0;
            for (int i = 0; i < W + 3; i++) begin
                @(negedge clk);
                if (done) ndone++;
            end
            check({tag, "_extra_done"}, ndone, 0);
            check({tag, "_result_kept"}, result, last_res);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   ndone;
        logic [W-1:0] x, y;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(4'b0010, 4'b0001, 1'b0, "add_2_1", -1);
        check("add_2_1_lit", {cout, result}, 5'b0_0011);
        @(negedge clk);
        check("done_single_cycle", done, 0);

        do_op(4'b1111, 4'b1111, 1'b0, "add_f_f", -1);
        check("add_f_f_lit", {cout, result}, 5'b1_1110);
        // Start accepted straight from DONE.
        do_op(4'b1000, 4'b0111, 1'b0, "add_8_7_b2b", -1);
        check("add_8_7_lit", {cout, result}, 5'b0_1111);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x = W'($urandom_range(0, (1 << W) - 1));
            y = W'($urandom_range(0, (1 << W) - 1));
            do_op(x, y, 1'b0, "sweep_add", -1);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            x = W'($urandom_range(0, (1 << W) - 1));
            y = W'($urandom_range(0, (1 << W) - 1));
            do_op(x, y, 1'b1, "sweep_sub", -1);
        end

        @(negedge clk);
        do_op(4'b0100, 4'b0011, 1'b1, "sub_4_3", -1);
        check("sub_4_3_lit", {cout, result}, 5'b0_0001);
        @(negedge clk);
        do_op(4'b0011, 4'b0100, 1'b1, "sub_3_4", -1);
        check("sub_3_4_lit", {cout, result}, 5'b1_1111);
        @(negedge clk);
        do_op(4'b0101, 4'b0101, 1'b1, "sub_5_5", -1);
        check("sub_5_5_lit", {cout, result}, 5'b0_0000);

        @(negedge clk);
        do_op(4'b1001, 4'b0011, 1'b0, "ignore_start", 2);
        check("ignore_start_lit", result, 4'b1100);

        // Reset in the middle of an operation: nothing completes.
        @(negedge clk);
        a = 4'b0111; b = 4'b0111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_cout", cout, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("midrst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        ndone = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        do_op(4'b0110, 4'b0101, 1'b0, "add_6_5", -1);
        check("add_6_5_lit", {cout, result}, 5'b0_1011);

`ifdef SERIAL_ADDSUB_OVF_EN
        @(negedge clk);
        do_op(4'b0111, 4'b0001, 1'b0, "ovf_add", -1);
        check("ovf_add_lit", {ovf, cout, result}, 6'b10_1000);
        @(negedge clk);
        do_op(4'b1000, 4'b0001, 1'b1, "ovf_sub", -1);
        check("ovf_sub_lit", {ovf, result}, 5'b1_0111);
        @(negedge clk);
        do_op(4'b0010, 4'b0001, 1'b0, "ovf_none", -1);
        check("ovf_none_lit", ovf, 0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
